// File: rtl/vdp_super_res_fetch.sv
// Super-resolution line fetcher: issues VRAM word reads for one line and buffers the
// returned words in a first-word-fall-through FIFO for the pixel consumer.
module vdp_super_res_fetch #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [8:0]        line_words,
  input  logic              pop,
  output logic [31:0]       word_out,
  output logic              word_valid,
  output logic              underrun,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW+1:0] DepthC = (CW + 2)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              underrun_q, underrun_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       fifo_q [DEPTH];

  logic              restart;
  logic [8:0]        words_eff;
  logic              ack_fire;
  logic              drop;
  logic              push;
  logic              pop_fire;
  logic [CW+1:0]     inflight_sum;

  // Next-state logic: memory handshake, FIFO bookkeeping, line restart and FSM.
  always_comb begin
    restart   = ~enable | line_start;
    words_eff = enable ? line_words : 9'd0;
    ack_fire  = mem_req_q & mem_ack;
    drop      = mem_rd_valid & (discard_q != '0);
    push      = mem_rd_valid & (discard_q == '0) & (outstanding_q != '0);
    pop_fire  = pop & (count_q != '0);

    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    underrun_d    = underrun_q;
    count_d       = count_q + CW'(push) - CW'(pop_fire);

    if (ack_fire) begin
      addr_d        = addr_q + 1'b1;
      remaining_d   = remaining_q - 9'd1;
      outstanding_d = outstanding_d + 1'b1;
    end
    if (drop) begin
      discard_d = discard_d - 1'b1;
    end
    if (push) begin
      outstanding_d = outstanding_d - 1'b1;
      wr_ptr_d      = wr_ptr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (pop && (count_q == '0)) begin
      underrun_d = 1'b1;
    end

    unique case (state_q)
      StFetch: if (remaining_d == 9'd0) state_d = StDrain;
      StDrain: if ((outstanding_d == '0) && (count_d == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Reads already accepted by memory for the old line must still be swallowed.
    if (restart) begin
      addr_d        = line_addr;
      remaining_d   = words_eff;
      discard_d     = discard_d + outstanding_d;
      outstanding_d = '0;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      underrun_d    = 1'b0;
      state_d       = (words_eff == 9'd0) ? StIdle : StFetch;
    end

    // Discarded reads are counted as in flight so the counters stay bounded by DEPTH.
    inflight_sum = (CW + 2)'(count_d) + (CW + 2)'(outstanding_d) + (CW + 2)'(discard_d);
    mem_req_d    = ~restart && (state_d == StFetch) && (remaining_d != 9'd0) &&
                   (inflight_sum < DepthC);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      underrun_q    <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      underrun_q    <= underrun_d;
      mem_req_q     <= mem_req_d;
    end
  end

  // FIFO storage; contents are only visible through word_out while non-empty.
  always_ff @(posedge clk) begin
    if (push && !restart) begin
      fifo_q[wr_ptr_q] <= mem_rd_data;
    end
  end

  assign word_valid = (count_q != '0);
  assign word_out   = word_valid ? fifo_q[rd_ptr_q] : 32'd0;
  assign underrun   = underrun_q;
  assign busy       = (state_q != StIdle);
  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;

endmodule

// File: tb/tb_vdp_super_res_fetch.sv
// Directed bench for vdp_super_res_fetch with a simple in-order memory model.
module tb_vdp_super_res_fetch;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 18;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b1;
  logic              line_start = 1'b0;
  logic [ADDR_W-1:0] line_addr = '0;
  logic [8:0]        line_words = '0;
  logic              pop = 1'b0;
  logic [31:0]       word_out;
  logic              word_valid;
  logic              underrun;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rd_valid;
  logic [31:0]       mem_rd_data;

  logic              ack_en = 1'b1;
  logic              rsp_en = 1'b1;
  logic [ADDR_W-1:0] rsp_q [$];
  logic [ADDR_W-1:0] req_log [$];

  int checks = 0;
  int errors = 0;

  vdp_super_res_fetch #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .line_start  (line_start),
    .line_addr   (line_addr),
    .line_words  (line_words),
    .pop         (pop),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .underrun    (underrun),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  assign mem_ack = mem_req & ack_en;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], 6'b101101, a};
  endfunction

  // Memory model: accepts on ack, returns data in order one or more cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q.delete();
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= '0;
    end else begin
      if (rsp_en && (rsp_q.size() > 0)) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= mem_word(rsp_q.pop_front());
      end else begin
        mem_rd_valid <= 1'b0;
        mem_rd_data  <= '0;
      end
      if (mem_req && mem_ack) begin
        rsp_q.push_back(mem_addr);
        req_log.push_back(mem_addr);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic start_line(input logic [ADDR_W-1:0] a, input logic [8:0] n);
    @(negedge clk);
    line_addr  = a;
    line_words = n;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Pops every available word, checking data and the request address sequence.
  task automatic consume(input logic [ADDR_W-1:0] a, input int n, input string tag);
    int got = 0;
    int cyc = 0;
    while (((got < n) || busy) && (cyc < 400)) begin
      if (word_valid) begin
        chk({tag, "_word"}, word_out, mem_word(ADDR_W'(a + ADDR_W'(got))));
        got++;
        pop = 1'b1;
      end else begin
        pop = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    pop = 1'b0;
    chk({tag, "_count"}, got, n);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_empty"}, word_valid, 1'b0);
    chk({tag, "_nreq"}, req_log.size(), n);
    for (int i = 0; i < n && i < req_log.size(); i++) begin
      chk({tag, "_addr"}, req_log[i], ADDR_W'(a + ADDR_W'(i)));
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [8:0]        words;
    int                delay;
    int                exp_pre;
    logic              exp_busy_pre;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic found;

    vecs[0] = '{addr: 18'h00100, words: 9'd4,  delay: 10, exp_pre: 4, exp_busy_pre: 1'b1};
    vecs[1] = '{addr: 18'h3FFFE, words: 9'd3,  delay: 10, exp_pre: 3, exp_busy_pre: 1'b1};
    vecs[2] = '{addr: 18'h00010, words: 9'd0,  delay: 5,  exp_pre: 0, exp_busy_pre: 1'b0};
    vecs[3] = '{addr: 18'h01000, words: 9'd20, delay: 20, exp_pre: 8, exp_busy_pre: 1'b1};
    vecs[4] = '{addr: 18'h3FFFC, words: 9'd9,  delay: 0,  exp_pre: 0, exp_busy_pre: 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_word_out", word_out, 32'd0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 18'd0);
    #2 reset_n = 1'b1;

    // Table-driven line fetches with zero-latency memory
    foreach (vecs[k]) begin
      req_log.delete();
      start_line(vecs[k].addr, vecs[k].words);
      repeat (vecs[k].delay) @(negedge clk);
      chk("pre_nreq", req_log.size(), vecs[k].exp_pre);
      chk("pre_busy", busy, vecs[k].exp_busy_pre);
      chk("pre_mem_req", mem_req, 1'b0);
      consume(vecs[k].addr, int'(vecs[k].words), "vec");
    end

    // Consumer stalls: credit limit holds requests at DEPTH, one new request per pop
    req_log.delete();
    start_line(18'h00800, 9'd180);
    repeat (30) @(negedge clk);
    chk("stall_nreq", req_log.size(), DEPTH);
    chk("stall_mem_req", mem_req, 1'b0);
    chk("stall_head", word_out, mem_word(18'h00800));
    for (int k = 0; k < 2; k++) begin
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      repeat (6) @(negedge clk);
      chk("pop_nreq", req_log.size(), DEPTH + 1 + k);
      chk("pop_mem_req", mem_req, 1'b0);
      chk("pop_head", word_out, mem_word(ADDR_W'(18'h00801 + ADDR_W'(k))));
    end
    // Enable low flushes and ignores line_start
    enable = 1'b0;
    line_start = 1'b1;
    repeat (3) @(negedge clk);
    line_start = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_valid", word_valid, 1'b0);
    chk("flush_mem_req", mem_req, 1'b0);
    chk("flush_word", word_out, 32'd0);
    enable = 1'b1;

    // Restart with reads outstanding: old data is discarded
    req_log.delete();
    rsp_en = 1'b0;
    start_line(18'h00300, 9'd10);
    cyc = 0;
    while ((req_log.size() < 3) && (cyc < 50)) begin
      @(negedge clk);
      cyc++;
    end
    ack_en = 1'b0;
    chk("os_nreq", req_log.size(), 3);
    repeat (3) @(negedge clk);
    chk("os_mem_req_held", mem_req, 1'b1);
    chk("os_mem_addr_held", mem_addr, 18'h00303);
    chk("os_valid", word_valid, 1'b0);
    req_log.delete();
    start_line(18'h00200, 9'd2);
    ack_en = 1'b1;
    rsp_en = 1'b1;
    consume(18'h00200, 2, "discard");

    // Underrun is sticky and does not disturb data
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("ur_set", underrun, 1'b1);
    chk("ur_valid", word_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("ur_held", underrun, 1'b1);
    @(negedge clk);
    line_addr  = 18'h00500;
    line_words = 9'd1;
    line_start = 1'b1;
    pop        = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    chk("ur_cleared", underrun, 1'b0);
    found = 1'b0;
    cyc   = 0;
    while (!found && (cyc < 20)) begin
      @(negedge clk);
      cyc++;
      if (word_valid) found = 1'b1;
    end
    chk("ur_push_found", found, 1'b1);
    chk("ur_push_word", word_out, mem_word(18'h00500));
    chk("ur_resets", underrun, 1'b1);
    @(negedge clk);
    pop = 1'b0;
    chk("ur_consumed", word_valid, 1'b0);
    chk("ur_idle", busy, 1'b0);

    // Asynchronous reset mid-fetch
    start_line(18'h00600, 9'd180);
    repeat (2) @(negedge clk);
    chk("ar_pre_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_mem_req", mem_req, 1'b0);
    chk("ar_mem_addr", mem_addr, 18'd0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_valid", word_valid, 1'b0);
    chk("ar_word", word_out, 32'd0);
    chk("ar_underrun", underrun, 1'b0);
    @(negedge clk);
    req_log.delete();
    line_addr  = 18'h00700;
    line_words = 9'd2;
    line_start = 1'b1;
    #2 reset_n = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    chk("ar_first_start", busy, 1'b1);
    consume(18'h00700, 2, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
